iir_change_reporter: RTL
========================

// Module: iir_change_reporter
// PURPOSE
//  Consumer of the smoothed sensor stream produced by the IIR low-pass stage.
//  Watches the filtered value on every sample strobe and, after a settle period, emits a
//  report only when the value moves by at least THRESHOLD for HOLD_SAMPLES consecutive samples.
//  Reports leave over a single-entry valid/ready port to the host-side register/UART logic.
// PARAMETERS
//  DATA_BITS      28  width of filtered input value (unsigned)
//  THRESHOLD      16  minimum |delta| vs. last reported value to qualify; legal >= 1
//  HOLD_SAMPLES   4   consecutive qualifying samples required; legal 1..255
//  SETTLE_SAMPLES 64  samples ignored after reset while filter converges; 0 allowed
// PORTS
//  CLK           in   1             single clock, all logic on posedge
//  RESET_N       in   1             asynchronous reset, active low
//  CE            in   1             sample strobe: IN_VALUE is valid this cycle
//  IN_VALUE      in   DATA_BITS     filtered value, unsigned
//  OUT_VALUE     out  DATA_BITS     reported value (new reference)
//  OUT_DELTA     out  DATA_BITS+1   signed OUT_VALUE minus previous reference
//  OUT_VALID     out  1             report pending
//  OUT_READY     in   1             consumer accepts report when OUT_VALID & OUT_READY
//  OVERRUN       out  1             sticky: an unaccepted report was overwritten
//  CLEAR_OVERRUN in   1             synchronous clear of OVERRUN
// BEHAVIOUR
//  - Reset (async, RESET_N=0): state=SETTLE, settle/hold counters=0, ref=0, OUT_VALUE=0,
//    OUT_DELTA=0, OUT_VALID=0, OVERRUN=0. Reset mid-report discards the pending report.
//  - Only CE=1 cycles advance state/counters; with CE=0 only handshake and CLEAR_OVERRUN act.
//  - SETTLE: count CE samples; on sample SETTLE_SAMPLES+1 (first if 0) load ref<=IN_VALUE,
//    issue initial report (OUT_VALUE=IN_VALUE, OUT_DELTA=0), go TRACK.
//  - TRACK: delta = {1'b0,IN_VALUE} - {1'b0,ref}, DATA_BITS+1 signed; no overflow possible.
//    |delta| fits DATA_BITS bits. Qualify when |delta| >= THRESHOLD.
//    qualify & same sign as previous qualifying sample: hold_cnt++.
//    qualify & sign changed (or hold_cnt=0): hold_cnt<=1.  not qualify: hold_cnt<=0.
//    When hold_cnt would reach HOLD_SAMPLES: report {IN_VALUE, delta}, ref<=IN_VALUE, hold_cnt<=0.
//  - Latency: report appears on OUT_* the cycle after the qualifying CE cycle.
//  - Output slot: OUT_VALUE/OUT_DELTA stable while OUT_VALID & !OUT_READY.
//    New report & slot empty: load, OUT_VALID<=1.
//    New report & OUT_VALID & OUT_READY same cycle: load new, OUT_VALID stays 1, no overrun.
//    New report & OUT_VALID & !OUT_READY: overwrite with new, OVERRUN<=1.
//    No report & OUT_VALID & OUT_READY: OUT_VALID<=0.
//  - CLEAR_OVERRUN and overrun event same cycle: OVERRUN stays 1 (set wins).
//  - No state returns to SETTLE except reset.
// STRUCTURE
//  - Shared header fpga_sensor_defs.vh: state encodings (SETTLE=2'd0, TRACK=2'd1).
//  - Sub-module change_report_slot: single-entry valid/ready register with overwrite and
//    sticky overrun; top holds settle counter, ref register, delta/abs/compare, hold FSM.
// TESTING
//  1 SETTLE_SAMPLES=4: 5 CE samples of 1000 -> one report VALUE=1000 DELTA=0, one cycle
//    after the 5th CE; nothing during the first 4 samples.
//  2 ref=1000, THRESHOLD=16, HOLD=4: 4 samples of 1020 -> report VALUE=1020 DELTA=+20 after
//    the 4th; 3 samples of 1020 then 1005 -> no report.
//  3 ref=1000: 2x 980, 2x 1020, 2x 1020 -> hold resets on sign flip; report only after the
//    4th consecutive 1020; 1x 984 (|delta|=16) counts as qualifying (>=).
//  4 OUT_READY=0 with two reports pending -> OUT_VALUE is the second report, OVERRUN=1;
//    CLEAR_OVERRUN pulse -> 0; report coinciding with accept -> no OVERRUN.
//  5 Extremes DATA_BITS=28: ref=0, IN=2^28-1 -> DELTA=+(2^28-1); reverse -> -(2^28-1).
//  6 RESET_N low mid-hold with OUT_VALID=1 -> all outputs 0 at once; settle restarts.

Source files
------------

// File: rtl/iir_change_reporter_pkg.sv
// rtl/iir_change_reporter_pkg.sv - shared types and constants for the change reporter
package iir_change_reporter_pkg;

    // Top-level tracking state; SETTLE is only ever re-entered through reset.
    typedef enum logic [1:0] {
        ST_SETTLE = 2'd0,
        ST_TRACK  = 2'd1
    } state_e;

    // Hold counter is sized for the largest legal HOLD_SAMPLES (255).
    localparam int unsigned HOLD_CNT_BITS = 8;

endpackage

// File: rtl/change_report_slot.sv
// rtl/change_report_slot.sv - single-entry valid/ready report register with sticky overrun
//
// Ports:
//   clk_i, rst_n_i        clock, asynchronous active-low reset
//   load_i                new report this cycle
//   value_i, delta_i      report payload
//   ready_i               consumer accepts when valid_o & ready_i
//   clear_overrun_i       synchronous clear of overrun_o (an overrun in the same cycle wins)
//   valid_o, value_o, delta_o  pending report
//   overrun_o             sticky: a pending, unaccepted report was overwritten
module change_report_slot #(
    parameter int unsigned DATA_BITS = 28
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  logic                 load_i,
    input  logic [DATA_BITS-1:0] value_i,
    input  logic [DATA_BITS:0]   delta_i,
    input  logic                 ready_i,
    input  logic                 clear_overrun_i,
    output logic                 valid_o,
    output logic [DATA_BITS-1:0] value_o,
    output logic [DATA_BITS:0]   delta_o,
    output logic                 overrun_o
);

    logic                 valid_q, valid_d;
    logic [DATA_BITS-1:0] value_q, value_d;
    logic [DATA_BITS:0]   delta_q, delta_d;
    logic                 overrun_q, overrun_d;
    logic                 overwrite;

    // Overwrite only counts when the old report is still pending and not taken this cycle.
    assign overwrite = load_i && valid_q && !ready_i;

    always_comb begin
        valid_d   = valid_q;
        value_d   = value_q;
        delta_d   = delta_q;
        overrun_d = overrun_q;
        if (load_i) begin
            valid_d = 1'b1;
            value_d = value_i;
            delta_d = delta_i;
        end else if (valid_q && ready_i) begin
            valid_d = 1'b0;
        end
        if (overwrite) begin
            overrun_d = 1'b1;
        end else if (clear_overrun_i) begin
            overrun_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            valid_q   <= 1'b0;
            value_q   <= '0;
            delta_q   <= '0;
            overrun_q <= 1'b0;
        end else begin
            valid_q   <= valid_d;
            value_q   <= value_d;
            delta_q   <= delta_d;
            overrun_q <= overrun_d;
        end
    end

    assign valid_o   = valid_q;
    assign value_o   = value_q;
    assign delta_o   = delta_q;
    assign overrun_o = overrun_q;

endmodule

// File: rtl/iir_change_reporter.sv
// rtl/iir_change_reporter.sv - reports filtered-value changes that persist past a threshold
//
// Ports:
//   clk_i, rst_n_i        clock, asynchronous active-low reset
//   ce_i, in_value_i      sample strobe and unsigned filtered value
//   out_value_o           reported value (becomes the new reference)
//   out_delta_o           signed report value minus previous reference
//   out_valid_o, out_ready_i   report handshake
//   overrun_o, clear_overrun_i sticky overwrite flag and its clear
module iir_change_reporter
    import iir_change_reporter_pkg::*;
#(
    parameter int unsigned DATA_BITS      = 28,
    parameter int unsigned THRESHOLD      = 16,
    parameter int unsigned HOLD_SAMPLES   = 4,
    parameter int unsigned SETTLE_SAMPLES = 64
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  logic                 ce_i,
    input  logic [DATA_BITS-1:0] in_value_i,
    output logic [DATA_BITS-1:0] out_value_o,
    output logic [DATA_BITS:0]   out_delta_o,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic                 overrun_o,
    input  logic                 clear_overrun_i
);

    // Wide enough to hold SETTLE_SAMPLES itself, and at least one bit when it is 0.
    localparam int unsigned SETTLE_BITS = $clog2(SETTLE_SAMPLES + 2);

    state_e                    state_q, state_d;
    logic [SETTLE_BITS-1:0]    settle_cnt_q, settle_cnt_d;
    logic [DATA_BITS-1:0]      ref_q, ref_d;
    logic [HOLD_CNT_BITS-1:0]  hold_cnt_q, hold_cnt_d, hold_next;
    logic                      prev_neg_q, prev_neg_d;

    logic signed [DATA_BITS:0] delta;
    logic [DATA_BITS:0]        abs_delta;
    logic                      qualify;
    logic                      report;
    logic [DATA_BITS:0]        rep_delta;

    // Both operands are zero-extended, so the one extra bit makes the difference exact.
    assign delta     = $signed({1'b0, in_value_i}) - $signed({1'b0, ref_q});
    assign abs_delta = delta[DATA_BITS] ? 
                       (DATA_BITS+1)'(-delta) : (DATA_BITS+1)'(delta);
    assign qualify   = abs_delta >= (DATA_BITS+1)'(THRESHOLD);

    always_comb begin
        state_d      = state_q;
        settle_cnt_d = settle_cnt_q;
        ref_d        = ref_q;
        hold_cnt_d   = hold_cnt_q;
        prev_neg_d   = prev_neg_q;
        hold_next    = '0;
        report       = 1'b0;
        rep_delta    = delta;
        if (ce_i) begin
            unique case (state_q)
                ST_SETTLE: begin
                    if (settle_cnt_q == SETTLE_BITS'(SETTLE_SAMPLES)) begin
                        // First post-settle sample becomes the reference and is reported as-is.
                        ref_d     = in_value_i;
                        report    = 1'b1;
                        rep_delta = '0;
                        state_d   = ST_TRACK;
                    end else begin
                        settle_cnt_d = settle_cnt_q + 1'b1;
                    end
                end
                ST_TRACK: begin
                    if (qualify) begin
                        // A run only continues while the excursion keeps the same direction.
                        if (hold_cnt_q != '0 && delta[DATA_BITS] == prev_neg_q) begin
                            hold_next = hold_cnt_q + 1'b1;
                        end else begin
                            hold_next = HOLD_CNT_BITS'(1);
                        end
                        prev_neg_d = delta[DATA_BITS];
                        if (hold_next == HOLD_CNT_BITS'(HOLD_SAMPLES)) begin
                            report     = 1'b1;
                            ref_d      = in_value_i;
                            hold_cnt_d = '0;
                        end else begin
                            hold_cnt_d = hold_next;
                        end
                    end else begin
                        hold_cnt_d = '0;
                    end
                end
                default: state_d = ST_TRACK;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q      <= ST_SETTLE;
            settle_cnt_q <= '0;
            ref_q        <= '0;
            hold_cnt_q   <= '0;
            prev_neg_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            settle_cnt_q <= settle_cnt_d;
            ref_q        <= ref_d;
            hold_cnt_q   <= hold_cnt_d;
            prev_neg_q   <= prev_neg_d;
        end
    end

    change_report_slot #(
        .DATA_BITS(DATA_BITS)
    ) u_slot (
        .clk_i          (clk_i),
        .rst_n_i        (rst_n_i),
        .load_i         (report),
        .value_i        (in_value_i),
        .delta_i        (rep_delta),
        .ready_i        (out_ready_i),
        .clear_overrun_i(clear_overrun_i),
        .valid_o        (out_valid_o),
        .value_o        (out_value_o),
        .delta_o        (out_delta_o),
        .overrun_o      (overrun_o)
    );

endmodule
